grid_draw_scheduler: RTL and testbench

Sequences pixel writes that render the 4-track x 16-step note grid into the 160x120 VGA frame-buffer adapter. It snapshots the four per-speaker pattern registers and the current beat, then walks every cell pixel by pixel, driving x/y/colour/plot. A redraw is triggered automatically whenever a pattern or the beat changes. It sits between the speakerPlay pattern outputs and vga_adapter, replacing free-running pixel generation.

---
 rtl/grid_draw_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_grid_draw_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_draw_scheduler.sv
// Purpose: walks the 4x16 note grid pixel by pixel into the VGA frame-buffer adapter; redraws on pattern/beat change (GRID_PARTIAL_REDRAW_EN: beat-only moves redraw two columns).
// Latency: LOAD + one pixel per enabled cycle + DONE, i.e. 2 + 64*CELL_W*CELL_H cycles per full frame.
// Backpressure: enable low freezes state and counters and drops plot; busy is unaffected.
module grid_draw_scheduler #(
    parameter int X0     = 20,
    parameter int Y0     = 30,
    parameter int CELL_W = 6,
    parameter int CELL_H = 8,
    parameter int GAP    = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enable,
    input  logic [15:0] qIn1,
    input  logic [15:0] qIn2,
    input  logic [15:0] qIn3,
    input  logic [15:0] qIn4,
    input  logic [3:0]  beat,
    output logic [7:0]  xOut,
    output logic [6:0]  yOut,
    output logic [2:0]  cOut,
    output logic        plot,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    localparam logic [2:0] PX_LAST = 3'(CELL_W - 1);
    localparam logic [2:0] PY_LAST = 3'(CELL_H - 1);
    localparam logic [7:0] X_BASE  = 8'(X0);
    localparam logic [7:0] X_PITCH = 8'(CELL_W + GAP);
    localparam logic [6:0] Y_BASE  = 7'(Y0);
    localparam logic [6:0] Y_PITCH = 7'(CELL_H + GAP);

    state_t           state_q, state_d;
    logic [3:0][15:0] q_in, snap_q, snap_d;
    logic [3:0]       snap_beat_q, snap_beat_d;
    logic [3:0]       old_beat_q, old_beat_d;
    logic             pending_q, pending_d;
    logic             short_q, short_d;
    logic             col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       step_q, step_d;
    logic [2:0]       px_q, px_d, py_q, py_d;
    logic             changed, short_start, last_pix;
    logic [3:0]       pix_step;
    logic             cell_on, cell_hit;
    logic [7:0]       x_d;
    logic [6:0]       y_d;
    logic [2:0]       c_d;

    assign q_in    = {qIn4, qIn3, qIn2, qIn1};
    assign changed = (q_in != snap_q) || (beat != snap_beat_q);

`ifdef GRID_PARTIAL_REDRAW_EN
    // Set by reset so the first frame after reset is always a full one.
    logic full_req_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            full_req_q <= 1'b1;
        end else if (state_q == LOAD && enable) begin
            full_req_q <= 1'b0;
        end
    end

    assign short_start = !full_req_q && (q_in == snap_q) && (beat != snap_beat_q);
`else
    assign short_start = 1'b0;
`endif

    // Short frames walk rows within a column; full frames walk steps within a row.
    assign last_pix = (px_q == PX_LAST) && (py_q == PY_LAST) && (row_q == 2'd3) &&
                      (short_q ? col_q : (step_q == 4'd15));

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        snap_beat_d = snap_beat_q;
        old_beat_d  = old_beat_q;
        pending_d   = pending_q | changed;
        short_d     = short_q;
        col_d       = col_q;
        row_d       = row_q;
        step_d      = step_q;
        px_d        = px_q;
        py_d        = py_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (pending_q) state_d = LOAD;
                end
                LOAD: begin
                    state_d     = DRAW;
                    snap_d      = q_in;
                    snap_beat_d = beat;
                    old_beat_d  = snap_beat_q;
                    short_d     = short_start;
                    pending_d   = 1'b0;
                    col_d       = 1'b0;
                    row_d       = 2'd0;
                    step_d      = 4'd0;
                    px_d        = 3'd0;
                    py_d        = 3'd0;
                end
                DRAW: begin
                    if (last_pix) state_d = DONE;
                    if (px_q != PX_LAST) begin
                        px_d = px_q + 3'd1;
                    end else begin
                        px_d = 3'd0;
                        if (py_q != PY_LAST) begin
                            py_d = py_q + 3'd1;
                        end else begin
                            py_d = 3'd0;
                            if (short_q) begin
                                row_d = row_q + 2'd1;
                                if (row_q == 2'd3) col_d = 1'b1;
                            end else begin
                                step_d = step_q + 4'd1;
                                if (step_q == 4'd15) row_d = row_q + 2'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = pending_q ? LOAD : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pixel for the next-cycle counters, so the registered outputs line up with the state.
    always_comb begin
        pix_step = short_d ? (col_d ? snap_beat_d : old_beat_d) : step_d;
        cell_on  = snap_d[row_d][pix_step];
        cell_hit = (pix_step == snap_beat_d);
        x_d      = X_BASE + X_PITCH * {4'd0, pix_step} + {5'd0, px_d};
        y_d      = Y_BASE + Y_PITCH * {5'd0, row_d} + {4'd0, py_d};
        c_d      = cell_on ? (cell_hit ? 3'b111 : 3'b010) : (cell_hit ? 3'b001 : 3'b000);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            snap_beat_q <= 4'd0;
            old_beat_q  <= 4'd0;
            pending_q   <= 1'b1;
            short_q     <= 1'b0;
            col_q       <= 1'b0;
            row_q       <= 2'd0;
            step_q      <= 4'd0;
            px_q        <= 3'd0;
            py_q        <= 3'd0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            snap_beat_q <= snap_beat_d;
            old_beat_q  <= old_beat_d;
            pending_q   <= pending_d;
            short_q     <= short_d;
            col_q       <= col_d;
            row_q       <= row_d;
            step_q      <= step_d;
            px_q        <= px_d;
            py_q        <= py_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            xOut <= 8'd0;
            yOut <= 7'd0;
            cOut <= 3'd0;
            plot <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (enable) begin
                plot <= (state_d == DRAW);
                done <= (state_q == DRAW) && (state_d == DONE);
                if (state_d == DRAW) begin
                    xOut <= x_d;
                    yOut <= y_d;
                    cOut <= c_d;
                end
            end else begin
                plot <= 1'b0;
                done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Bench for grid_draw_scheduler: pixel scoreboard fed by a scan model, frame-length and boundary checks per scenario.
module tb_grid_draw_scheduler;
    localparam int BX0 = 20, BY0 = 30, BW = 6, BH = 8, BG = 2;
    localparam int FULL_LEN  = 1 + 64 * BW * BH + 1;
    localparam int SHORT_LEN = 1 + 8 * BW * BH + 1;

    logic        clk = 1'b0;
    logic        resetN, enable;
    logic [15:0] qIn1, qIn2, qIn3, qIn4;
    logic [3:0]  beat;
    logic [7:0]  xOut;
    logic [6:0]  yOut;
    logic [2:0]  cOut;
    logic        plot, busy, done;

    grid_draw_scheduler dut (
        .clk(clk), .resetN(resetN), .enable(enable),
        .qIn1(qIn1), .qIn2(qIn2), .qIn3(qIn3), .qIn4(qIn4), .beat(beat),
        .xOut(xOut), .yOut(yOut), .cOut(cOut), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          print_cnt = 0;
    logic        busy_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [17:0] exp_q[$];
    int          len_q[$];
    logic [7:0]  last_x = 8'd0;
    logic [6:0]  last_y = 7'd0;

    // Scoreboard: every plotted pixel must match the next modelled pixel; frame lengths are logged.
    always @(negedge clk) begin
        logic [17:0] e;
        cyc++;
        if (plot) begin
            last_x = xOut;
            last_y = yOut;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                if (print_cnt < 20) $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%b, expected no plot", xOut, yOut, cOut);
                print_cnt++;
            end else begin
                e = exp_q.pop_front();
                if ({xOut, yOut, cOut} !== e) begin
                    errors++;
                    if (print_cnt < 20) $display("FAIL pixel: got x=%0d y=%0d c=%b, expected x=%0d y=%0d c=%b",
                                                 xOut, yOut, cOut, e[17:10], e[9:3], e[2:0]);
                    print_cnt++;
                end
            end
        end
        if (busy && (!busy_prev || done_prev)) start_cyc = cyc;
        if (done) len_q.push_back(cyc - start_cyc + 1);
        busy_prev = busy;
        done_prev = done;
    end

    function automatic logic [2:0] exp_colour(input logic [15:0] pat, input int step, input int bt);
        if (pat[step]) return (step == bt) ? 3'b111 : 3'b010;
        return (step == bt) ? 3'b001 : 3'b000;
    endfunction

    task automatic push_cell(input logic [15:0] pat, input int row, input int step, input int bt);
        for (int py = 0; py < BH; py++)
            for (int px = 0; px < BW; px++)
                exp_q.push_back({8'(BX0 + step * (BW + BG) + px), 7'(BY0 + row * (BH + BG) + py),
                                 exp_colour(pat, step, bt)});
    endtask

    // Queues the frame the DUT should draw for the current inputs; returns its expected length.
    task automatic push_redraw(input int old_b, input bit pat_same, output int len);
        logic [15:0] pats[4];
        int          bt;
        pats = '{qIn1, qIn2, qIn3, qIn4};
        bt   = int'(beat);
        len  = FULL_LEN;
`ifdef GRID_PARTIAL_REDRAW_EN
        if (pat_same && old_b != bt) begin
            len = SHORT_LEN;
            for (int r = 0; r < 4; r++) push_cell(pats[r], r, old_b, bt);
            for (int r = 0; r < 4; r++) push_cell(pats[r], r, bt, bt);
            return;
        end
`endif
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 16; s++) push_cell(pats[r], r, s, bt);
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_plot(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (plot) ok = 1'b1;
        end
    endtask

    task automatic get_len(output int len);
        len = (len_q.size() != 0) ? len_q.pop_front() : -1;
    endtask

    task automatic test_reset();
        bit ok;
        int len, el;
        resetN = 1'b0; enable = 1'b1; beat = 4'd0;
        qIn1 = 16'h0; qIn2 = 16'h0; qIn3 = 16'h0; qIn4 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({xOut, yOut, cOut, plot, busy, done} !== 21'd0) begin
            errors++; $display("FAIL reset_outputs: got %h, expected 0", {xOut, yOut, cOut, plot, busy, done});
        end
        push_redraw(0, 1'b0, el);
        @(negedge clk);
        resetN = 1'b1;
        wait_plot(10, ok);
        checks++;
        if (!ok || xOut !== 8'd20 || yOut !== 7'd30 || cOut !== 3'b001) begin
            errors++; $display("FAIL first_pixel: got ok=%0d x=%0d y=%0d c=%b, expected (20,30) c=001", ok, xOut, yOut, cOut);
        end
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != el) begin errors++; $display("FAIL reset_frame_len: got %0d, expected %0d", len, el); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            errors++; $display("FAIL idle_after_frame: got busy=%b plot=%b, expected 0 0", busy, plot);
        end
    endtask

    task automatic test_beat_change();
        bit ok;
        int len, el, ex;
        @(posedge clk); #1;
        qIn1 = 16'h0001;
        push_redraw(0, 1'b0, el);
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != el) begin errors++; $display("FAIL pattern_frame_len: got %0d, expected %0d", len, el); end
        beat = 4'd5;
        push_redraw(0, 1'b1, el);
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != el) begin errors++; $display("FAIL beat_frame_len: got %0d, expected %0d", len, el); end
        ex = (el == FULL_LEN) ? BX0 + 15 * (BW + BG) + BW - 1 : BX0 + 5 * (BW + BG) + BW - 1;
        checks++;
        if (int'(last_x) != ex || int'(last_y) != BY0 + 3 * (BH + BG) + BH - 1) begin
            errors++; $display("FAIL last_pixel: got (%0d,%0d), expected (%0d,%0d)", last_x, last_y, ex, BY0 + 3 * (BH + BG) + BH - 1);
        end
    endtask

    task automatic test_mid_draw_change();
        bit ok;
        int len, el;
        qIn3 = 16'h00F0;
        push_redraw(5, 1'b0, el);
        repeat (500) @(posedge clk);
        #1 qIn3 = 16'h0F00;
        repeat (200) @(posedge clk);
        #1 qIn3 = 16'h1234;
        push_redraw(5, 1'b0, el);
        for (int f = 0; f < 2; f++) begin
            wait_done(4000, ok);
            get_len(len);
            checks++;
            if (!ok || len != FULL_LEN) begin errors++; $display("FAIL midchange_frame%0d_len: got %0d, expected %0d", f, len, FULL_LEN); end
        end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || len_q.size() != 0) begin
            errors++; $display("FAIL single_extra_frame: got busy=%b extra_frames=%0d, expected 0 0", busy, len_q.size());
        end
    endtask

    task automatic test_enable_hold();
        bit         ok;
        int         len, el, bad;
        logic [7:0] hx;
        logic [6:0] hy;
        qIn4 = 16'h8001;
        push_redraw(5, 1'b0, el);
        repeat (300) @(posedge clk);
        #1;
        enable = 1'b0;
        hx = xOut; hy = yOut; bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (plot !== 1'b0 || xOut !== hx || yOut !== hy || busy !== 1'b1) bad++;
        end
        enable = 1'b1;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL enable_hold: got %0d bad cycles, expected 0", bad); end
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != FULL_LEN + 100) begin errors++; $display("FAIL enable_frame_len: got %0d, expected %0d", len, FULL_LEN + 100); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int len, el;
        qIn2 = 16'hAAAA;
        push_redraw(5, 1'b0, el);
        repeat (1000) @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        checks++;
        if ({xOut, yOut, cOut, plot, busy, done} !== 21'd0) begin
            errors++; $display("FAIL async_reset: got %h, expected 0", {xOut, yOut, cOut, plot, busy, done});
        end
        exp_q.delete();
        repeat (3) @(posedge clk);
        push_redraw(5, 1'b0, el);
        @(negedge clk);
        resetN = 1'b1;
        wait_plot(10, ok);
        checks++;
        if (!ok || xOut !== 8'd20 || yOut !== 7'd30 || cOut !== 3'b010) begin
            errors++; $display("FAIL restart_pixel: got ok=%0d x=%0d y=%0d c=%b, expected (20,30) c=010", ok, xOut, yOut, cOut);
        end
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != FULL_LEN) begin errors++; $display("FAIL restart_frame_len: got %0d, expected %0d", len, FULL_LEN); end
    endtask

    task automatic test_beat_only();
        bit ok;
        int len, el, ex;
        @(posedge clk); #1;
        beat = 4'd3;
        push_redraw(5, 1'b1, el);
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != el) begin errors++; $display("FAIL beat3_frame_len: got %0d, expected %0d", len, el); end
        beat = 4'd4;
        push_redraw(3, 1'b1, el);
`ifdef GRID_PARTIAL_REDRAW_EN
        ex = 44;
`else
        ex = 20;
`endif
        wait_plot(10, ok);
        checks++;
        if (!ok || int'(xOut) != ex || yOut !== 7'd30) begin
            errors++; $display("FAIL beat4_first_pixel: got ok=%0d (%0d,%0d), expected (%0d,30)", ok, xOut, yOut, ex);
        end
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != el) begin errors++; $display("FAIL beat4_frame_len: got %0d, expected %0d", len, el); end
        qIn2 = 16'h5555;
        push_redraw(4, 1'b0, el);
        wait_done(4000, ok);
        get_len(len);
        checks++;
        if (!ok || len != FULL_LEN) begin errors++; $display("FAIL pattern_full_len: got %0d, expected %0d", len, FULL_LEN); end
    endtask

    initial begin
        test_reset();
        test_beat_change();
        test_mid_draw_change();
        test_enable_hold();
        test_reset_mid_frame();
        test_beat_only();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL undrawn_pixels: got %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
